// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a small register file (ID, status, control bytes, error counter).
// SCK, MOSI and CS are oversampled on sysclk; all decoding uses the synchronised copies.
module spi_reg_responder #(
    parameter logic [7:0]  DEVICE_ID   = 8'hC6,
    parameter int unsigned NUM_CTRL    = 4,
    parameter logic [7:0]  CTRL_RESET  = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  sysclk,
    input  logic                  reset_INV,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_INV,
    output logic                  spi_miso,
    input  logic [7:0]            status_in,
    output logic [8*NUM_CTRL-1:0] ctrl_regs,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic [7:0]            err_count
);

    typedef enum logic [2:0] {WAIT_DESEL, IDLE, CMD, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic                   sck_s, mosi_s, cs_s, sck_d, cs_d;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;

    state_t                 state, state_nxt;
    logic [4:0]             bit_cnt, bit_cnt_nxt;
    logic [6:0]             shift, shift_nxt;
    logic [7:0]             rd_shift, rd_shift_nxt;
    logic                   is_read, is_read_nxt;
    logic [6:0]             addr, addr_nxt;
    logic                   miso_nxt, wr_strobe_nxt;
    logic [6:0]             wr_addr_nxt;
    logic [7:0]             err_nxt, rd_byte;
    logic [8*NUM_CTRL-1:0]  ctrl_nxt;
    logic [7:0]             sample;

    // CS synchroniser resets to "selected" so a frame in flight at reset release is skipped.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_INV};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign sample   = {shift, mosi_s};

    always_comb begin
        rd_byte = '0;
        if (sample[6:0] == 7'd0)
            rd_byte = DEVICE_ID;
        else if (sample[6:0] == 7'd1)
            rd_byte = status_in;
        else if (sample[6:0] == 7'(NUM_CTRL + 2))
            rd_byte = err_count;
        for (int unsigned k = 0; k < NUM_CTRL; k++)
            if (sample[6:0] == 7'(k + 2))
                rd_byte = ctrl_regs[8*k +: 8];
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        rd_shift_nxt  = rd_shift;
        is_read_nxt   = is_read;
        addr_nxt      = addr;
        miso_nxt      = spi_miso;
        ctrl_nxt      = ctrl_regs;
        wr_strobe_nxt = 1'b0;
        wr_addr_nxt   = wr_addr;
        err_nxt       = err_count;
        case (state)
            WAIT_DESEL: begin
                miso_nxt = 1'b0;
                if (cs_s)
                    state_nxt = IDLE;
            end
            IDLE: begin
                miso_nxt = 1'b0;
                if (cs_fall) begin
                    state_nxt   = CMD;
                    bit_cnt_nxt = '0;
                    shift_nxt   = '0;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    miso_nxt  = 1'b0;
                    state_nxt = IDLE;
                    if (bit_cnt != 5'd0 && err_count != 8'hFF)
                        err_nxt = err_count + 8'd1;
                end else if (sck_rise) begin
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    shift_nxt   = sample[6:0];
                    if (bit_cnt == 5'd7) begin
                        is_read_nxt  = sample[7];
                        addr_nxt     = sample[6:0];
                        rd_shift_nxt = sample[7] ? rd_byte : 8'h00;
                        state_nxt    = DATA;
                    end
                end
            end
            DATA: begin
                if (cs_rise) begin
                    miso_nxt  = 1'b0;
                    state_nxt = IDLE;
                    if (err_count != 8'hFF)
                        err_nxt = err_count + 8'd1;
                end else if (sck_rise) begin
                    bit_cnt_nxt = (bit_cnt < 5'd16) ? bit_cnt + 5'd1 : bit_cnt;
                    shift_nxt   = sample[6:0];
                    if (bit_cnt == 5'd15) begin
                        miso_nxt  = 1'b0;
                        state_nxt = DONE;
                        if (!is_read)
                            for (int unsigned k = 0; k < NUM_CTRL; k++)
                                if (addr == 7'(k + 2)) begin
                                    ctrl_nxt[8*k +: 8] = sample;
                                    wr_strobe_nxt      = 1'b1;
                                    wr_addr_nxt        = addr;
                                end
                    end
                end else if (sck_fall) begin
                    miso_nxt     = rd_shift[7];
                    rd_shift_nxt = {rd_shift[6:0], 1'b0};
                end
            end
            DONE: begin
                miso_nxt = 1'b0;
                if (cs_rise)
                    state_nxt = IDLE;
            end
            default: state_nxt = WAIT_DESEL;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state     <= WAIT_DESEL;
            bit_cnt   <= '0;
            shift     <= '0;
            rd_shift  <= '0;
            is_read   <= 1'b0;
            addr      <= '0;
            spi_miso  <= 1'b0;
            ctrl_regs <= {NUM_CTRL{CTRL_RESET}};
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            rd_shift  <= rd_shift_nxt;
            is_read   <= is_read_nxt;
            addr      <= addr_nxt;
            spi_miso  <= miso_nxt;
            ctrl_regs <= ctrl_nxt;
            wr_strobe <= wr_strobe_nxt;
            wr_addr   <= wr_addr_nxt;
            err_count <= err_nxt;
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: directed and random SPI frames checked against
// a register-file model updated per whole frame.
module tb_spi_reg_responder;

    localparam int unsigned NUM_CTRL = 4;
    localparam logic [7:0]  DEV_ID   = 8'hC6;

    logic                  sysclk = 1'b0;
    logic                  reset_INV, spi_clk, spi_mosi, spi_cs_INV, spi_miso, wr_strobe;
    logic [7:0]            status_in, err_count;
    logic [8*NUM_CTRL-1:0] ctrl_regs;
    logic [6:0]            wr_addr;

    spi_reg_responder #(
        .DEVICE_ID  (DEV_ID),
        .NUM_CTRL   (NUM_CTRL),
        .CTRL_RESET (8'h00),
        .SYNC_STAGES(2)
    ) dut (
        .sysclk    (sysclk),
        .reset_INV (reset_INV),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_cs_INV(spi_cs_INV),
        .spi_miso  (spi_miso),
        .status_in (status_in),
        .ctrl_regs (ctrl_regs),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err_count (err_count)
    );

    always #5 sysclk = ~sysclk;

    int unsigned n_cmp = 0, n_bad = 0, strobe_cycles = 0;
    logic [6:0]  last_wr_addr = '0;
    logic [7:0]  ctrl_model [NUM_CTRL];
    int unsigned err_model;

    always @(negedge sysclk)
        if (wr_strobe === 1'b1) begin
            strobe_cycles++;
            last_wr_addr = wr_addr;
        end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_pack();
        logic [31:0] v = '0;
        for (int k = 0; k < NUM_CTRL; k++) v[8*k +: 8] = ctrl_model[k];
        return v;
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        int ai = int'(a);
        if (ai == 0) return DEV_ID;
        if (ai == 1) return status_in;
        if (ai >= 2 && ai < 2 + NUM_CTRL) return ctrl_model[ai-2];
        if (ai == 2 + NUM_CTRL) return 8'(err_model);
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CTRL; k++) ctrl_model[k] = 8'h00;
        err_model = 0;
    endtask

    task automatic half();
        repeat (6) @(negedge sysclk);
    endtask

    // Master sets MOSI, samples MISO just before the rising edge.
    task automatic sck_bit(input logic b, output logic m);
        spi_mosi = b;
        half();
        m = spi_miso;
        spi_clk = 1'b1;
        half();
        spi_clk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [15:0] word, input int unsigned nbits, output logic [7:0] rd);
        logic b, m;
        rd = '0;
        spi_cs_INV = 1'b0;
        half();
        for (int unsigned i = 0; i < nbits; i++) begin
            if (i < 16) b = word[15-i];
            else        b = 1'($urandom);
            sck_bit(b, m);
            if (i >= 8 && i < 16) rd[15-i] = m;
        end
        half();
        spi_cs_INV = 1'b1;
        half();
        half();
    endtask

    task automatic do_frame(input logic [15:0] word, input int unsigned nbits);
        logic [7:0]  rd, exp_rd;
        int unsigned s0, exp_str;
        int          a;
        exp_rd  = word[15] ? model_read(word[14:8]) : 8'h00;
        a       = int'(word[14:8]);
        s0      = strobe_cycles;
        exp_str = 0;
        spi_xfer(word, nbits, rd);
        if (nbits >= 1 && nbits <= 15) begin
            if (err_model < 255) err_model++;
        end else if (nbits >= 16 && !word[15] && a >= 2 && a < 2 + NUM_CTRL) begin
            ctrl_model[a-2] = word[7:0];
            exp_str = 1;
        end
        if (nbits >= 16) check_eq("miso_byte", 32'(rd), 32'(exp_rd));
        check_eq("strobe_cycles", strobe_cycles - s0, exp_str);
        if (exp_str != 0) check_eq("wr_addr", 32'(last_wr_addr), 32'(word[14:8]));
        check_eq("ctrl_regs", ctrl_regs, model_pack());
        check_eq("err_count", 32'(err_count), err_model);
        check_eq("miso_idle", 32'(spi_miso), 32'd0);
    endtask

    task automatic check_reset_values();
        check_eq("rst_miso", 32'(spi_miso), 32'd0);
        check_eq("rst_ctrl", ctrl_regs, 32'd0);
        check_eq("rst_strobe", 32'(wr_strobe), 32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic        m;
        int unsigned s0, r, nb;
        logic [6:0]  a;

        reset_INV = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_INV = 1'b1; status_in = 8'h00;
        model_reset();
        repeat (5) @(negedge sysclk);
        check_reset_values();
        reset_INV = 1'b1;
        repeat (10) @(negedge sysclk);

        // write, reads of ID/status/ctrl
        do_frame(16'h02A5, 16);
        do_frame(16'h8000, 16);
        status_in = 8'h3C;
        do_frame(16'h8100, 16);
        do_frame(16'h8255, 16);

        // aborted write, then read of error counter
        do_frame(16'h035A, 10);
        do_frame(16'h8600, 16);
        do_frame(16'h0000, 0);

        // ignored writes and an over-long write
        do_frame(16'h0011, 16);
        do_frame(16'h0122, 16);
        do_frame(16'h0633, 16);
        do_frame(16'h7F44, 16);
        do_frame(16'h04E7, 20);
        do_frame(16'h8400, 16);

        // error counter saturation
        for (int i = 0; i < 300; i++)
            do_frame(16'($urandom), $urandom_range(1, 3));
        do_frame(16'h8600, 16);

        // reset in the middle of a frame
        w = 16'h0377;
        spi_cs_INV = 1'b0;
        half();
        for (int i = 0; i < 4; i++) sck_bit(w[15-i], m);
        spi_mosi = w[11];
        half();
        spi_clk = 1'b1;
        reset_INV = 1'b0;
        model_reset();
        repeat (3) @(negedge sysclk);
        check_reset_values();
        reset_INV = 1'b1;
        s0 = strobe_cycles;
        half();
        spi_clk = 1'b0;
        for (int i = 5; i < 16; i++) sck_bit(w[15-i], m);
        half();
        spi_cs_INV = 1'b1;
        half();
        half();
        check_eq("midrst_strobe", strobe_cycles - s0, 0);
        check_eq("midrst_err", 32'(err_count), 32'd0);
        check_eq("midrst_ctrl", ctrl_regs, 32'd0);
        do_frame(16'h0377, 16);
        do_frame(16'h8300, 16);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            status_in = 8'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 8));
            w = {1'($urandom), a, 8'($urandom)};
            r = $urandom_range(0, 9);
            if (r == 6)      nb = 0;
            else if (r == 7) nb = $urandom_range(1, 15);
            else if (r == 8) nb = $urandom_range(17, 20);
            else             nb = 16;
            do_frame(w, nb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
